// File: rtl/pulse_meter.sv
// pulse_meter: synchronises an async pulse and measures its high width,
// period and count in clock cycles, with a sticky saturation flag.
module pulse_meter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             signal,
   input  logic             enable,
   output logic [WIDTH-1:0] high_width,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] pulse_count,
   output logic             valid,
   output logic             overflow
);

   localparam logic [WIDTH-1:0] MAX = '1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t state, state_n;

   logic s1, s2, s3;
   logic rise, fall;

   logic [WIDTH-1:0] hcnt, hcnt_n;
   logic [WIDTH-1:0] pcnt, pcnt_n;
   logic [WIDTH-1:0] hinc, pinc;
   logic [WIDTH-1:0] high_width_n, period_n, pulse_count_n;
   logic             valid_n, overflow_n;

   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (v == MAX) ? MAX : v + ONE;
   endfunction

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;
   assign hinc = sat_inc(hcnt);
   assign pinc = sat_inc(pcnt);

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         state       <= IDLE;
         hcnt        <= '0;
         pcnt        <= '0;
         high_width  <= '0;
         period      <= '0;
         pulse_count <= '0;
         valid       <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         s1          <= signal;
         s2          <= s1;
         s3          <= s2;
         state       <= state_n;
         hcnt        <= hcnt_n;
         pcnt        <= pcnt_n;
         high_width  <= high_width_n;
         period      <= period_n;
         pulse_count <= pulse_count_n;
         valid       <= valid_n;
         overflow    <= overflow_n;
      end
   end

   // Reaching MAX through an increment is what marks saturation.
   always_comb begin
      state_n       = state;
      hcnt_n        = hcnt;
      pcnt_n        = pcnt;
      high_width_n  = high_width;
      period_n      = period;
      pulse_count_n = pulse_count;
      valid_n       = 1'b0;
      overflow_n    = overflow;
      if (!enable) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise) begin
                  hcnt_n        = ONE;
                  pcnt_n        = ONE;
                  pulse_count_n = pulse_count + ONE;
                  state_n       = HIGH;
               end
            end
            HIGH: begin
               pcnt_n = pinc;
               if (pinc == MAX) overflow_n = 1'b1;
               if (fall) begin
                  high_width_n = hcnt;
                  state_n      = LOW;
               end else begin
                  hcnt_n = hinc;
                  if (hinc == MAX) overflow_n = 1'b1;
               end
            end
            LOW: begin
               if (rise) begin
                  period_n      = pcnt;
                  valid_n       = 1'b1;
                  pulse_count_n = pulse_count + ONE;
                  hcnt_n        = ONE;
                  pcnt_n        = ONE;
                  state_n       = HIGH;
               end else begin
                  pcnt_n = pinc;
                  if (pinc == MAX) overflow_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule
